mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates a single shared memory port between the instruction-fetch requester (read-only) and the load/store requester (read/write with byte mask).
- Uses a req/ack handshake, so a unified SRAM with variable latency can replace the fixed-ack separate instruction/data memories.
- Sits between ifu/exu and the memory.
- Adds data-priority arbitration, an instruction anti-starvation guard, and a per-transaction timeout.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte mask width is DW/8.
- STARVE_MAX, 4, consecutive data grants allowed while i_req is pending before instruction is forced.
- TIMEOUT, 64, cycles to wait for m_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction fetch request.
- i_addr  in  AW  fetch address.
- i_ack  out  1  one-cycle completion pulse to fetch.
- i_rdata  out  DW  fetch data; valid while i_ack=1.
- d_req  in  1  load/store request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_wmask  in  DW/8  store byte enables.
- d_ack  out  1  one-cycle completion pulse to load/store.
- d_rdata  out  DW  load data; valid while d_ack=1.
- err  out  1  pulses with i_ack/d_ack when the transaction timed out.
- m_req  out  1  shared memory request.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_wmask  out  DW/8  memory byte enables.
- m_ack  in  1  memory completion; m_rdata valid in the same cycle.
- m_rdata  in  DW  memory read data.
- grant  out  2  current owner: 00 none, 01 instruction, 10 data.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, starve_cnt=0, timer=0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - d_req=1 and (i_req=0 or starve_cnt<STARVE_MAX) → latch data request, grant=10.
  - Else if i_req=1 → latch fetch request, grant=01.
  - Else stay in IDLE.
  - On any grant, go to BUSY and clear timer.
- Latched request signals:
  - m_addr/m_we/m_wdata/m_wmask are driven from registers captured at grant.
  - They stay stable through BUSY even if requester inputs change.
  - Fetch grant: m_we=0, m_wmask=0, m_wdata=0.
  - Data load: m_wmask=0.
- BUSY:
  - m_req=1.
  - On m_ack=1: capture m_rdata into the response register (stores capture 0), go to RESP, m_req=0 next cycle.
  - Otherwise timer increments. When timer reaches TIMEOUT-1 without m_ack (TIMEOUT>0): set err flag, response data=0, go to RESP.
- RESP:
  - Exactly one cycle.
  - Owning ack=1, rdata=captured data, err=flag.
  - grant stays at owner, then FSM returns to IDLE with grant=00.
  - Non-owning ack/rdata stay 0; rdata outputs are 0 whenever the corresponding ack is 0.
- Latency: request sampled in IDLE at cycle N → m_req at N+1 → ack at N+2+(memory wait cycles).
- Minimum 3-cycle turnaround per transaction.
- Requester protocol:
  - Hold req and its payload until ack.
  - Deassert or change req in the cycle after ack.
  - The arbiter does not sample req in BUSY/RESP.
  - Withdrawing req while pending is a protocol violation; the transaction still completes and the ack is still issued.
- starve_cnt:
  - Increments when data is granted while i_req=1, saturating at STARVE_MAX.
  - Clears when instruction is granted or when i_req=0 at a data grant.
- Simultaneous i_req and d_req with starve_cnt<STARVE_MAX: data wins.
- m_ack outside BUSY is ignored.
- m_ack in the same cycle the timeout fires: the ack wins and err=0.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight transaction is dropped, with no ack.
- At most one outstanding memory transaction; no pipelining.

Test Plan:
- Single fetch:
  - Stimulus: i_req=1, i_addr=0x100; memory acks 1 cycle after m_req with 0xDEADBEEF.
  - Response: m_addr=0x100, m_we=0; i_ack at cycle 3 with i_rdata=0xDEADBEEF; grant=01 through RESP; err=0.
- Store with mask:
  - Stimulus: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0x11223344, d_wmask=0011; memory acks after 3 wait cycles.
  - Response: m_wmask=0011 and m_wdata stable for all BUSY cycles; d_ack one cycle; d_rdata=0.
- Contention and starvation:
  - Stimulus: i_req and d_req both held; each transaction is re-requested immediately after its ack.
  - Response: grant sequence is D,D,D,D,I,D,D,D,D,I with STARVE_MAX=4.
- Timeout:
  - Stimulus: TIMEOUT=8, d_req load, m_ack never arrives.
  - Response: after 8 BUSY cycles, d_ack=1, err=1, d_rdata=0; FSM returns to IDLE.
- Ack/timeout collision:
  - Stimulus: m_ack=1 exactly on the timeout cycle, with m_rdata=0x5A5A5A5A.
  - Response: ack with data 0x5A5A5A5A and err=0.
- Reset mid-transaction:
  - Stimulus: assert rst during BUSY.
  - Response: m_req, grant, i_ack and d_ack go to 0 asynchronously; no ack is issued after release; the next request is arbitrated normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: one port multiplexed between instruction fetch and
// load/store, with data priority, fetch anti-starvation and an ack timeout.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ack,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wmask,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            err,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wmask,
  input  logic            m_ack,
  input  logic [DW-1:0]   m_rdata,
  output logic [1:0]      grant
);

  localparam int MW = DW / 8;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   starve_q, starve_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= GNT_NONE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    timer_d  = timer_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (d_req && (!i_req || (starve_q < SMAX))) begin
          state_d = BUSY;
          grant_d = GNT_D;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wmask_d = d_we ? d_wmask : '0;
          timer_d = '0;
          err_d   = 1'b0;
          // Winning over a pending fetch implies starve_q < SMAX, so this saturates.
          starve_d = i_req ? starve_q + SW'(1) : '0;
        end else if (i_req) begin
          state_d  = BUSY;
          grant_d  = GNT_I;
          we_d     = 1'b0;
          addr_d   = i_addr;
          wdata_d  = '0;
          wmask_d  = '0;
          timer_d  = '0;
          err_d    = 1'b0;
          starve_d = '0;
        end
      end
      BUSY: begin
        if (m_ack) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : m_rdata;
          err_d   = 1'b0;
        end else if ((TIMEOUT > 0) && (timer_q == TLAST)) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  assign m_req   = (state_q == BUSY);
  assign m_we    = we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_wmask = wmask_q;
  assign grant   = grant_q;
  assign i_ack   = (state_q == RESP) && (grant_q == GNT_I);
  assign d_ack   = (state_q == RESP) && (grant_q == GNT_D);
  assign i_rdata = i_ack ? rdata_q : '0;
  assign d_rdata = d_ack ? rdata_q : '0;
  assign err     = (state_q == RESP) && err_q;

endmodule
